// File: rtl/arb_mux_n.sv
// N-channel registered selector with valid/ready handshake, fixed or round-robin arbitration.
// Optional `ARB_MUX_LOCK_EN adds in_lock to pin round-robin grant to the last granted channel.
module arb_mux_n #(
  parameter int WIDTH = 16,
  parameter int NCH   = 4,
  parameter int SELW  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel,
  input  logic [NCH-1:0]       in_valid,
  input  logic [NCH*WIDTH-1:0] in_data,
`ifdef ARB_MUX_LOCK_EN
  input  logic                 in_lock,
`endif
  output logic [NCH-1:0]       in_ready,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_ch,
  input  logic                 out_ready
);

  localparam int          PW   = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int unsigned NCHU = NCH;

  typedef enum logic {
    ARB_FIXED = 1'b0,
    ARB_RR    = 1'b1
  } arb_mode_e;

  arb_mode_e      mode_e;
  logic [PW-1:0]  rr_ptr;
  logic [PW-1:0]  gidx;
  logic [PW-1:0]  scan_idx;
  logic [NCH-1:0] grant;
  logic [WIDTH-1:0] gdata;
  logic           found;
  logic           ld;
  logic           xfer;

`ifdef ARB_MUX_LOCK_EN
  logic           lock_q;
`endif

  assign mode_e = arb_mode_e'(mode);

  always_comb begin
    grant    = '0;
    gidx     = '0;
    found    = 1'b0;
    scan_idx = '0;
    if (mode_e == ARB_FIXED) begin
      // Out-of-range sel matches no channel, so it simply yields no grant.
      for (int unsigned i = 0; i < NCHU; i++) begin
        if (32'(sel) == i) begin
          grant[PW'(i)] = in_valid[PW'(i)];
          gidx          = PW'(i);
        end
      end
    end
`ifdef ARB_MUX_LOCK_EN
    else if (lock_q) begin
      grant[rr_ptr] = in_valid[rr_ptr];
      gidx          = rr_ptr;
    end
`endif
    else begin
      for (int unsigned k = 1; k <= NCHU; k++) begin
        scan_idx = PW'((32'(rr_ptr) + k) % NCHU);
        if (!found && in_valid[scan_idx]) begin
          found           = 1'b1;
          grant[scan_idx] = 1'b1;
          gidx            = scan_idx;
        end
      end
    end
  end

  always_comb begin
    gdata = '0;
    for (int unsigned i = 0; i < NCHU; i++) begin
      if (grant[PW'(i)]) gdata = in_data[i*WIDTH +: WIDTH];
    end
  end

  assign ld       = ~out_valid | out_ready;
  // Reset level gates acceptance so no source sees a handshake while the register is held clear.
  assign in_ready = grant & {NCH{ld & rst_n}};
  assign xfer     = |in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      rr_ptr    <= PW'(NCH - 1);
    end else begin
      if (ld) begin
        out_valid <= xfer;
        if (xfer) begin
          out_data <= gdata;
          out_ch   <= SELW'(gidx);
        end
      end
      if (xfer) rr_ptr <= gidx;
    end
  end

`ifdef ARB_MUX_LOCK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   lock_q <= 1'b0;
    else if (mode_e == ARB_FIXED) lock_q <= 1'b0;
    else if (xfer)                lock_q <= in_lock;
  end
`endif

endmodule

// File: tb/tb_arb_mux_n.sv
// Self-checking bench for arb_mux_n: vector table plus hand sequences, output words scoreboarded.
module tb_arb_mux_n;

  logic        clk;
  logic        rst_n;
  logic        mode;
  logic [1:0]  sel;
  logic [3:0]  in_valid;
  logic [63:0] in_data;
  logic [3:0]  in_ready;
  logic        out_valid;
  logic [15:0] out_data;
  logic [1:0]  out_ch;
  logic        out_ready;
`ifdef ARB_MUX_LOCK_EN
  logic        in_lock;
  logic        lk;
`endif

  typedef struct {
    bit         md;
    logic [1:0] s;
    logic [3:0] v;
    bit         ordy;
    logic [3:0] er;
  } vec_t;

  typedef struct {
    logic [1:0]  ch;
    logic [15:0] d;
  } word_t;

  vec_t  tbl [17];
  word_t exp_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  logic [63:0] dd;

  arb_mux_n #(.WIDTH(16), .NCH(4), .SELW(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .sel       (sel),
    .in_valid  (in_valid),
    .in_data   (in_data),
`ifdef ARB_MUX_LOCK_EN
    .in_lock   (in_lock),
`endif
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  function automatic logic [63:0] gen(input int s);
    logic [63:0] r;
    for (int i = 0; i < 4; i++) r[i*16 +: 16] = 16'((i << 12) | (s & 12'hFFF));
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Drive one cycle of stimulus, check combinational ready and the registered word, advance.
  task automatic apply(input bit md, input logic [1:0] s, input logic [3:0] v, input bit ordy,
                       input logic [63:0] d, input logic [3:0] er, input string nm);
    bit    exp_ov;
    word_t w;
    mode      = md;
    sel       = s;
    in_valid  = v;
    out_ready = ordy;
    in_data   = d;
`ifdef ARB_MUX_LOCK_EN
    in_lock   = lk;
`endif
    #1;
    chk($sformatf("%s.in_ready", nm), 32'(in_ready), 32'(er));
    exp_ov = (exp_q.size() != 0);
    chk($sformatf("%s.out_valid", nm), 32'(out_valid), 32'(exp_ov));
    if (exp_ov) begin
      chk($sformatf("%s.out_data", nm), 32'(out_data), 32'(exp_q[0].d));
      chk($sformatf("%s.out_ch", nm), 32'(out_ch), 32'(exp_q[0].ch));
      if (ordy) void'(exp_q.pop_front());
    end
    for (int i = 0; i < 4; i++) begin
      if (er[i] && v[i]) begin
        w.ch = 2'(i);
        w.d  = d[i*16 +: 16];
        exp_q.push_back(w);
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    tbl = '{
      '{1'b1, 2'd0, 4'hF, 1'b1, 4'h1}, '{1'b1, 2'd0, 4'hF, 1'b1, 4'h2},
      '{1'b1, 2'd0, 4'hF, 1'b1, 4'h4}, '{1'b1, 2'd0, 4'hF, 1'b1, 4'h8},
      '{1'b1, 2'd0, 4'hF, 1'b1, 4'h1}, '{1'b1, 2'd0, 4'hF, 1'b1, 4'h2},
      '{1'b1, 2'd0, 4'hF, 1'b1, 4'h4}, '{1'b1, 2'd0, 4'hF, 1'b1, 4'h8},
      '{1'b1, 2'd0, 4'hA, 1'b1, 4'h2}, '{1'b1, 2'd0, 4'hA, 1'b1, 4'h8},
      '{1'b1, 2'd0, 4'hA, 1'b1, 4'h2}, '{1'b1, 2'd0, 4'hA, 1'b1, 4'h8},
      '{1'b0, 2'd0, 4'hF, 1'b1, 4'h1}, '{1'b0, 2'd3, 4'h7, 1'b1, 4'h0},
      '{1'b0, 2'd1, 4'hF, 1'b1, 4'h2}, '{1'b1, 2'd0, 4'hF, 1'b1, 4'h4},
      '{1'b1, 2'd0, 4'h0, 1'b1, 4'h0}
    };
`ifdef ARB_MUX_LOCK_EN
    lk      = 1'b0;
    in_lock = 1'b0;
`endif
    rst_n     = 1'b0;
    mode      = 1'b1;
    sel       = 2'd0;
    in_valid  = 4'hF;
    in_data   = gen(0);
    out_ready = 1'b1;

    // Reset state with every channel requesting
    repeat (2) @(negedge clk);
    #1;
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.out_data", 32'(out_data), 32'd0);
    chk("rst.out_ch", 32'(out_ch), 32'd0);
    chk("rst.in_ready", 32'(in_ready), 32'd0);
    rst_n = 1'b1;

    for (int k = 0; k < 17; k++)
      apply(tbl[k].md, tbl[k].s, tbl[k].v, tbl[k].ordy, gen(k + 1), tbl[k].er,
            $sformatf("vec%0d", k));

    // Fixed select of ch2 carrying BEEF
    dd = gen(50);
    dd[47:32] = 16'hBEEF;
    apply(1'b0, 2'd2, 4'hF, 1'b1, dd, 4'h4, "fix_sel2");

    // Backpressure: 1234 held for 5 stalled cycles, then pop and push on one edge
    dd = gen(51);
    dd[31:16] = 16'h1234;
    apply(1'b0, 2'd1, 4'hF, 1'b1, dd, 4'h2, "bp_load");
    for (int k = 0; k < 5; k++)
      apply(1'b0, 2'd1, 4'hF, 1'b0, gen(52 + k), 4'h0, $sformatf("bp_stall%0d", k));
    apply(1'b0, 2'd3, 4'hF, 1'b1, gen(57), 4'h8, "bp_release");
    apply(1'b1, 2'd0, 4'h3, 1'b1, gen(58), 4'h1, "rr_wrap");
    apply(1'b1, 2'd0, 4'h2, 1'b1, gen(59), 4'h2, "rr_ch1");

    // Asynchronous reset between edges while the register holds a word
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst.out_valid", 32'(out_valid), 32'd0);
    chk("arst.out_data", 32'(out_data), 32'd0);
    chk("arst.out_ch", 32'(out_ch), 32'd0);
    chk("arst.in_ready", 32'(in_ready), 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    apply(1'b1, 2'd0, 4'hF, 1'b1, gen(60), 4'h1, "arst_ptr");
    apply(1'b1, 2'd0, 4'h0, 1'b1, gen(61), 4'h0, "arst_drain");

`ifdef ARB_MUX_LOCK_EN
    lk = 1'b1;
    apply(1'b1, 2'd0, 4'h4, 1'b1, gen(70), 4'h4, "lock_set");
    lk = 1'b0;
    for (int k = 0; k < 3; k++)
      apply(1'b1, 2'd0, 4'h3, 1'b1, gen(71 + k), 4'h0, $sformatf("lock_hold%0d", k));
    apply(1'b1, 2'd0, 4'h7, 1'b1, gen(74), 4'h4, "lock_clear");
    apply(1'b1, 2'd0, 4'hB, 1'b1, gen(75), 4'h8, "lock_next3");
    apply(1'b1, 2'd0, 4'h3, 1'b1, gen(76), 4'h1, "lock_next0");
    apply(1'b1, 2'd0, 4'h0, 1'b1, gen(77), 4'h0, "lock_drain");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
